// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame-shape defaults
// and parity-mode constants.
package uart_pkg;

  // Transmitter states; encoding is visible on the debug state output.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } uart_state_e;

  // Frame-shape defaults.
  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_STOP_BITS = 1;

  // Value of parity_odd selecting each parity mode.
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_tick.sv
// UART transmitter paced by an external one-clock baud_tick enable.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity bit,
// STOP_BITS stop bits. Each baud_tick edge advances exactly one bit.
//
// Handshake: a word is taken on a rising clk edge where tx_valid and
// tx_ready are both high; tx_ready is high only in IDLE, so the inputs are
// ignored for the whole frame. busy is high from acceptance until the tick
// that ends the last stop bit.
module uart_tx_tick
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int STOP_BITS = DEF_STOP_BITS
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic                 txd,
  output logic                 busy,
  output logic [2:0]           state_dbg
);

  localparam int CW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [CW-1:0]        bit_q,   bit_d;
  logic                 stop_q,  stop_d;
  logic                 pen_q,   pen_d;
  logic                 par_q,   par_d;
  logic                 txd_q,   txd_d;

  // State and datapath registers; reset drops any partial frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      pen_q   <= 1'b0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      pen_q   <= pen_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
    end
  end

  // Next-state logic: accept in IDLE, otherwise advance one bit per tick.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    pen_d   = pen_q;
    par_d   = par_q;
    txd_d   = txd_q;

    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          state_d = ST_SYNC;
          shreg_d = tx_data;
          bit_d   = '0;
          stop_d  = 1'b0;
          pen_d   = parity_en;
          // Parity is fixed at acceptance so later input changes cannot leak in.
          par_d   = (parity_odd == PARITY_ODD) ? ~(^tx_data) : (^tx_data);
        end
      end
      ST_SYNC: begin
        // Wait for a tick boundary so the start bit lasts a full period.
        if (baud_tick) begin
          state_d = ST_START;
          txd_d   = 1'b0;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          state_d = ST_DATA;
          txd_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          if (bit_q == LAST_BIT) begin
            if (pen_q) begin
              state_d = ST_PARITY;
              txd_d   = par_q;
            end else begin
              state_d = ST_STOP;
              txd_d   = 1'b1;
              stop_d  = 1'b0;
            end
          end else begin
            bit_d   = bit_q + CW'(1);
            txd_d   = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (baud_tick) begin
          state_d = ST_STOP;
          txd_d   = 1'b1;
          stop_d  = 1'b0;
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          if (stop_q == LAST_STOP) begin
            state_d = ST_IDLE;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  assign tx_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign txd       = txd_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_tick.sv
// Directed bench for uart_tx_tick: a vector table of frames with hand-written
// expected serial bit strings, plus sequences for back-to-back acceptance
// and mid-frame reset. Two instances: 8N1 and 7-bit / 2 stop bits.
module tb_uart_tx_tick;

  logic       clk;
  logic       rstn;
  logic       baud_tick;
  logic [7:0] tx_data;
  logic       tx_valid8, tx_valid7;
  logic       parity_en, parity_odd;
  logic       tx_ready8, txd8, busy8;
  logic       tx_ready7, txd7, busy7;
  logic [2:0] state8, state7;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_div = 4;
  int tick_cnt = 0;
  logic tick_at_edge = 1'b0;
  int sel = 0;

  logic m_txd, m_busy, m_ready;
  assign m_txd   = (sel != 0) ? txd7      : txd8;
  assign m_busy  = (sel != 0) ? busy7     : busy8;
  assign m_ready = (sel != 0) ? tx_ready7 : tx_ready8;

  uart_tx_tick #(.DATA_BITS(8), .STOP_BITS(1)) dut8 (
    .clk(clk), .rstn(rstn), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_valid(tx_valid8), .tx_ready(tx_ready8), .parity_en(parity_en),
    .parity_odd(parity_odd), .txd(txd8), .busy(busy8), .state_dbg(state8)
  );

  uart_tx_tick #(.DATA_BITS(7), .STOP_BITS(2)) dut7 (
    .clk(clk), .rstn(rstn), .baud_tick(baud_tick), .tx_data(tx_data[6:0]),
    .tx_valid(tx_valid7), .tx_ready(tx_ready7), .parity_en(parity_en),
    .parity_odd(parity_odd), .txd(txd7), .busy(busy7), .state_dbg(state7)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge; remember the tick the DUT just saw,
  // then generate the tick for the coming rising edge.
  task automatic step();
    @(negedge clk);
    tick_at_edge = baud_tick;
    if (tick_div <= 1) begin
      baud_tick = 1'b1;
    end else begin
      tick_cnt  = (tick_cnt + 1) % tick_div;
      baud_tick = (tick_cnt == 0);
    end
  endtask

  // Offer a word to the selected instance and confirm it is taken at the next edge.
  task automatic send(input int s, input logic [7:0] d, input logic pen, input logic podd);
    sel        = s;
    tx_data    = d;
    parity_en  = pen;
    parity_odd = podd;
    if (s != 0) tx_valid7 = 1'b1; else tx_valid8 = 1'b1;
    step();
    check("accept_busy", 32'(m_busy), 32'd1);
    check("accept_ready", 32'(m_ready), 32'd0);
    tx_valid7 = 1'b0;
    tx_valid8 = 1'b0;
  endtask

  // Record txd after every tick edge until busy falls, and compare with the
  // expected bit string; txd must hold between ticks and tx_ready stay low.
  task automatic capture(input string tag, input string exp_s, input int div);
    logic bits [0:15];
    int   nb   = 0;
    int   cyc  = 1;
    logic last = 1'b1;
    bit   done = 1'b0;
    for (int k = 0; k < 400; k++) begin
      step();
      if (!m_busy) begin
        done = 1'b1;
        break;
      end
      cyc++;
      check({tag, "_ready_low"}, 32'(m_ready), 32'd0);
      if (tick_at_edge) begin
        if (nb < 16) bits[nb] = m_txd;
        last = m_txd;
        nb++;
      end else begin
        check({tag, "_hold"}, 32'(m_txd), 32'(last));
      end
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_nbits"}, 32'(nb), 32'(exp_s.len()));
    for (int i = 0; i < exp_s.len() && i < nb && i < 16; i++)
      check($sformatf("%s_bit%0d", tag, i), 32'(bits[i]), 32'((exp_s[i] == "1") ? 1 : 0));
    check({tag, "_busy_min"}, 32'(cyc >= exp_s.len() * div), 32'd1);
    check({tag, "_busy_max"}, 32'(cyc <= exp_s.len() * div + div), 32'd1);
    check({tag, "_ready_back"}, 32'(m_ready), 32'd1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       pen;
    logic       podd;
    int         div;
    int         s;
    string      exp_s;  // serial bits in line order: start, data LSB first, parity, stops
  } vec_t;

  vec_t vecs [6];

  initial begin
    int nt;
    vecs[0] = '{8'h55, 1'b0, 1'b0, 4, 0, "0101010101"};
    vecs[1] = '{8'h07, 1'b1, 1'b0, 3, 0, "01110000011"};
    vecs[2] = '{8'h07, 1'b1, 1'b1, 2, 0, "01110000001"};
    vecs[3] = '{8'hA3, 1'b0, 1'b0, 1, 0, "0110001011"};
    vecs[4] = '{8'h41, 1'b0, 1'b0, 3, 1, "0100000111"};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 2, 1, "00000000111"};

    rstn = 1'b0; baud_tick = 1'b0; tx_data = '0;
    tx_valid8 = 1'b0; tx_valid7 = 1'b0; parity_en = 1'b0; parity_odd = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd8", 32'(txd8), 32'd1);
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_ready8", 32'(tx_ready8), 32'd1);
    check("rst_txd7", 32'(txd7), 32'd1);
    check("rst_busy7", 32'(busy7), 32'd0);
    check("rst_ready7", 32'(tx_ready7), 32'd1);
    rstn = 1'b1;

    for (int v = 0; v < 6; v++) begin
      tick_div = vecs[v].div;
      send(vecs[v].s, vecs[v].data, vecs[v].pen, vecs[v].podd);
      capture($sformatf("vec%0d", v), vecs[v].exp_s, vecs[v].div);
    end

    // tx_valid held with data switched to 0xFF mid-frame: 0x12 goes out,
    // then 0xFF is taken on the edge right after the return to IDLE.
    tick_div = 2;
    sel = 0; tx_data = 8'h12; parity_en = 1'b0; parity_odd = 1'b0; tx_valid8 = 1'b1;
    step();
    check("b2b_accept1", 32'(busy8), 32'd1);
    tx_data = 8'hFF;
    capture("b2b_f1", "0010010001", 2);
    step();
    check("b2b_accept2", 32'(busy8), 32'd1);
    tx_valid8 = 1'b0;
    capture("b2b_f2", "0111111111", 2);

    // Reset during data bit 3 of 0x52 (bit 3 = 0), then a clean frame.
    tick_div = 4;
    send(0, 8'h52, 1'b0, 1'b0);
    nt = 0;
    for (int k = 0; k < 200 && nt < 5; k++) begin
      step();
      if (tick_at_edge && busy8) nt++;
    end
    check("rst_mid_reached", 32'(nt), 32'd5);
    check("rst_mid_bit3", 32'(txd8), 32'd0);
    rstn = 1'b0;
    #1;
    check("rst_mid_txd", 32'(txd8), 32'd1);
    check("rst_mid_busy", 32'(busy8), 32'd0);
    check("rst_mid_ready", 32'(tx_ready8), 32'd1);
    step();
    check("rst_mid_hold_txd", 32'(txd8), 32'd1);
    rstn = 1'b1;
    send(0, 8'h3C, 1'b0, 1'b0);
    capture("post_rst", "0001111001", 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
